// File: rtl/prz_pkg.sv
// Shared widths and FSM state encoding for the program counter block.
package prz_pkg;
  localparam int ADDR_WIDTH_PC = 12;
  localparam int INSTR_WIDTH   = 16;

  typedef enum logic [1:0] {
    S_RUN  = 2'd0,
    S_INIT = 2'd1,
    S_DONE = 2'd2
  } state_e;
endpackage

// File: rtl/prog_counter_if.sv
// Control, WISHBONE-load and PRAM-side signals of the program counter.
interface prog_counter_if;
  import prz_pkg::*;

  logic                     inc_i;
  logic                     adr_ld_i;
  logic [ADDR_WIDTH_PC-1:0] adr_pc_i;
  logic                     call_i;
  logic                     ret_i;
  logic                     stall_i;
  logic                     init_mode_i;
  // wb_valid_i qualifies data_wb_bus_i; there is no ready: every valid cycle
  // in S_INIT is consumed as one PRAM write, valid cycles elsewhere are ignored.
  logic                     wb_valid_i;
  logic [INSTR_WIDTH-1:0]   data_wb_bus_i;
  logic [ADDR_WIDTH_PC-1:0] pram_adr_o;
  logic                     pram_we_o;
  logic [INSTR_WIDTH-1:0]   pram_wdata_o;
  logic                     init_done_o;
  logic                     stack_err_o;
  state_e                   state_o;

  modport master (
    output inc_i, adr_ld_i, adr_pc_i, call_i, ret_i, stall_i, init_mode_i,
           wb_valid_i, data_wb_bus_i,
    input  pram_adr_o, pram_we_o, pram_wdata_o, init_done_o, stack_err_o, state_o
  );

  modport slave (
    input  inc_i, adr_ld_i, adr_pc_i, call_i, ret_i, stall_i, init_mode_i,
           wb_valid_i, data_wb_bus_i,
    output pram_adr_o, pram_we_o, pram_wdata_o, init_done_o, stack_err_o, state_o
  );
endinterface

// File: rtl/prog_counter_ret_stack.sv
// Register-based LIFO for return addresses; only the pointer is reset.
module ret_stack #(
  parameter int DEPTH = 8,
  parameter int W     = 12
) (
  input  logic         clk_i,
  input  logic         a_reset_l,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic         flush_i,
  input  logic [W-1:0] push_data_i,
  output logic [W-1:0] pop_data_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = $clog2(DEPTH);

  logic [PW:0]   sp_q, sp_d;
  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] top_idx;

  assign full_o     = (sp_q == (PW+1)'(DEPTH));
  assign empty_o    = (sp_q == '0);
  assign top_idx    = PW'(sp_q - 1'b1);
  assign pop_data_o = mem_q[top_idx];

  always_comb begin
    sp_d = sp_q;
    if (flush_i)                 sp_d = '0;
    else if (push_i && !full_o)  sp_d = sp_q + 1'b1;
    else if (pop_i && !empty_o)  sp_d = sp_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!a_reset_l) sp_q <= '0;
    else            sp_q <= sp_d;
  end

  // Entries keep their contents across reset; an empty pointer hides them.
  always_ff @(posedge clk_i) begin
    if (push_i && !full_o && !flush_i) mem_q[sp_q[PW-1:0]] <= push_data_i;
  end
endmodule

// File: rtl/prog_counter.sv
// Program counter with call/return stack and PRAM program-image loader.
module prog_counter
  import prz_pkg::*;
#(
  parameter int STACK_DEPTH = 8,
  parameter int INIT_WORDS  = 4096
) (
  input  logic           clk_i,
  input  logic           a_reset_l,
  prog_counter_if.slave  pc_if
);
  localparam logic [ADDR_WIDTH_PC-1:0] LAST_ADR = ADDR_WIDTH_PC'(INIT_WORDS - 1);
  localparam logic [ADDR_WIDTH_PC-1:0] ONE      = ADDR_WIDTH_PC'(1);

  state_e                   state_q, state_d;
  logic [ADDR_WIDTH_PC-1:0] pc_q, pc_d;
  logic                     err_q, err_d;
  logic                     done_q, done_d;
  logic                     push, pop, flush, full, empty;
  logic [ADDR_WIDTH_PC-1:0] pop_data;

  ret_stack #(.DEPTH(STACK_DEPTH), .W(ADDR_WIDTH_PC)) u_stack (
    .clk_i       (clk_i),
    .a_reset_l   (a_reset_l),
    .push_i      (push),
    .pop_i       (pop),
    .flush_i     (flush),
    .push_data_i (pc_q + ONE),
    .pop_data_o  (pop_data),
    .full_o      (full),
    .empty_o     (empty)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    err_d   = err_q;
    done_d  = 1'b0;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    case (state_q)
      S_RUN: begin
        if (pc_if.init_mode_i) begin
          state_d = S_INIT;
          pc_d    = '0;
          flush   = 1'b1;
        end else if (pc_if.stall_i) begin
          pc_d = pc_q;
        end else if (pc_if.ret_i) begin
          if (!empty) begin
            pop  = 1'b1;
            pc_d = pop_data;
          end else begin
            pc_d  = '0;
            err_d = 1'b1;
          end
        end else if (pc_if.call_i) begin
          // The jump is taken even when the return address cannot be saved.
          if (!full) push  = 1'b1;
          else       err_d = 1'b1;
          pc_d = pc_if.adr_pc_i;
        end else if (pc_if.adr_ld_i) begin
          pc_d = pc_if.adr_pc_i;
        end else if (pc_if.inc_i) begin
          pc_d = pc_q + ONE;
        end
      end
      S_INIT: begin
        if (pc_if.wb_valid_i) begin
          if (pc_q == LAST_ADR) begin
            state_d = S_DONE;
            pc_d    = '0;
            done_d  = 1'b1;
          end else begin
            pc_d = pc_q + ONE;
          end
        end
      end
      S_DONE: begin
        state_d = S_RUN;
        pc_d    = '0;
      end
      default: begin
        state_d = S_RUN;
        pc_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!a_reset_l) begin
      state_q <= S_RUN;
      pc_q    <= '0;
      err_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
      done_q  <= done_d;
    end
  end

  // Write strobe is gated by reset so a reset cycle mid-load never writes.
  assign pc_if.pram_we_o    = (state_q == S_INIT) && pc_if.wb_valid_i && a_reset_l;
  assign pc_if.pram_wdata_o = (state_q == S_INIT) ? pc_if.data_wb_bus_i : '0;
  assign pc_if.pram_adr_o   = pc_q;
  assign pc_if.init_done_o  = done_q;
  assign pc_if.stack_err_o  = err_q;
  assign pc_if.state_o      = state_q;
endmodule
